// File: rtl/pll_rst_pkg.sv
// Purpose: shared state encoding and default timing constants for the PLL lock/reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    PLL_RST   = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_CNT_W               = 20;

endpackage

// File: rtl/lock_sync.sv
// Purpose: two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk edges from first sampling to q.
// Backpressure: none; free-running level path.
module lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_rst_seq.sv
// Purpose: hold downstream reset until the PLL shows a stable lock; restart the PLL on lock timeout.
// Latency: rst_out falls LOCK_STABLE_CYCLES+2 edges after pll_lock is first sampled high; rises 2 edges after loss.
// Backpressure: none; outputs are registered levels, no handshake.
module pll_lock_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst_out,
  output logic       rst_out,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  // Terminal timer values: every state leaves on the cycle its timer hits these, so it never wraps.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PLL_RST_CYCLES - 1);

  logic             lock_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       lost_d;
  logic             rst_out_d, ready_d, pll_rst_d;

  lock_sync #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // State, timer and all outputs are registered; outputs reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_LOCK;
      timer_q       <= '0;
      lock_lost_cnt <= 8'd0;
      rst_out       <= 1'b1;
      ready         <= 1'b0;
      pll_rst_out   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      lock_lost_cnt <= lost_d;
      rst_out       <= rst_out_d;
      ready         <= ready_d;
      pll_rst_out   <= pll_rst_d;
    end
  end

  // Next-state, shared timer and loss counter; output values decoded from the next state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lost_d  = lock_lost_cnt;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      PLL_RST: begin
        // Lock flag is meaningless while the PLL is held in reset.
        if (timer_q == PULSE_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      STABLE: begin
        // Any dropout sends us back to WAIT_LOCK, so the stable count restarts from zero.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
          if (lock_lost_cnt != 8'hFF) begin
            lost_d = lock_lost_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        timer_d = '0;
      end
    endcase

    rst_out_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    pll_rst_d = (state_d == PLL_RST);
  end

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
module tb_pll_lock_rst_seq;

  localparam int LSC = 4;
  localparam int LTC = 100;
  localparam int PRC = 16;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_rst_out;
  logic       rst_out;
  logic       ready;
  logic [7:0] lock_lost_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  pll_lock_rst_seq #(
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .PLL_RST_CYCLES     (PRC),
    .CNT_W              (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .pll_rst_out  (pll_rst_out),
    .rst_out      (rst_out),
    .ready        (ready),
    .lock_lost_cnt(lock_lost_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: counts qualified lock samples seen two edges late, idle
  // wait time, and remaining restart-pulse cycles.
  bit m_valid = 1'b0;
  bit m_s1, m_s2, m_ls, m_run;
  int m_restart, m_wait, m_streak, m_lost;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_run = 0;
      m_restart = 0; m_wait = 0; m_streak = 0; m_lost = 0;
      m_valid = 1'b1;
    end else begin
      m_ls = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_lock;
      if (m_restart > 0) begin
        m_restart--;
      end else if (m_run) begin
        if (!m_ls) begin
          m_run = 0; m_wait = 0; m_streak = 0;
          if (m_lost < 255) m_lost++;
        end
      end else if (m_ls) begin
        // First qualified sample starts the count; LSC more are needed.
        m_streak++;
        if (m_streak == LSC + 1) begin
          m_run = 1; m_streak = 0;
        end
      end else if (m_streak > 0) begin
        m_streak = 0; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == LTC) begin
          m_restart = PRC; m_wait = 0;
        end
      end
    end
  end

  // Every cycle after the first reset edge the outputs must match the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_rst_out", 32'(rst_out), 32'(!m_run));
      chk("model_ready", 32'(ready), 32'(m_run));
      chk("model_pll_rst_out", 32'(pll_rst_out), 32'(m_restart > 0));
      chk("model_lock_lost_cnt", 32'(lock_lost_cnt), 32'(m_lost));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic lvl, output int r);
    @(negedge clk);
    rst = 1'b1;
    pll_lock = lvl;
    step(3);
    rst = 1'b0;
    r = cyc;
  endtask

  // sel 0: rst_out, sel 1: pll_rst_out. Returns edge index, or -1 on timeout.
  task automatic wait_for(input int sel, input logic val, input int budget, output int e);
    logic v;
    e = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      v = (sel == 0) ? rst_out : pll_rst_out;
      if (v === val) begin
        e = cyc;
        break;
      end
    end
  endtask

  initial begin
    int k, e, e1, e2, r, w;

    // Reset state
    step(3);
    chk("reset_rst_out", 32'(rst_out), 32'd1);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_pll_rst_out", 32'(pll_rst_out), 32'd0);
    chk("reset_cnt", 32'(lock_lost_cnt), 32'd0);
    rst = 1'b0;

    // Lock one cycle after release: RUN after edge k+6
    step(1);
    pll_lock = 1'b1;
    k = cyc + 1;
    wait_for(0, 1'b0, 50, e);
    chk("lock_to_run_edges", e - k, 6);
    chk("run_ready", 32'(ready), 32'd1);
    chk("run_no_pll_rst", 32'(pll_rst_out), 32'd0);

    // One-cycle loss in RUN
    step(3);
    pll_lock = 1'b0;
    k = cyc + 1;
    step(1);
    pll_lock = 1'b1;
    wait_for(0, 1'b1, 10, e);
    chk("loss_latency_le3", 32'(e >= 0 && (e - k) <= 3), 32'd1);
    chk("loss_cnt_one", 32'(lock_lost_cnt), 32'd1);
    wait_for(0, 1'b0, 30, e2);
    chk("relock_to_run_edges", e2 - (k + 1), 6);

    // Dropout in STABLE after 2 stable cycles restarts the count
    do_reset(1'b0, r);
    step(1);
    pll_lock = 1'b1;
    k = cyc + 1;
    step(3);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    wait_for(0, 1'b0, 50, e);
    chk("stable_dropout_run_edge", e - k, 10);

    // Lock held low: restart pulses
    do_reset(1'b0, r);
    wait_for(1, 1'b1, 200, e1);
    chk("timeout_first_pulse", e1 - r, 100);
    w = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pll_rst_out === 1'b1) w++;
      else break;
    end
    chk("pulse_width", w, 16);
    wait_for(1, 1'b1, 200, e2);
    chk("pulse_period", e2 - e1, 116);

    // Reset in pulse cycle 5
    step(4);
    rst = 1'b1;
    step(1);
    chk("midpulse_rst_pll_rst_out", 32'(pll_rst_out), 32'd0);
    chk("midpulse_rst_rst_out", 32'(rst_out), 32'd1);
    rst = 1'b0;
    r = cyc;
    wait_for(1, 1'b1, 200, e);
    chk("midpulse_rst_rewait", e - r, 100);

    // Loss-counter saturation
    do_reset(1'b0, r);
    step(1);
    pll_lock = 1'b1;
    wait_for(0, 1'b0, 50, e);
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      step(1);
      pll_lock = 1'b1;
      step(9);
      if (i == 9)   chk("cnt_after_10", 32'(lock_lost_cnt), 32'd10);
      if (i == 254) chk("cnt_after_255", 32'(lock_lost_cnt), 32'd255);
    end
    chk("cnt_saturated", 32'(lock_lost_cnt), 32'd255);
    chk("run_after_many", 32'(ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
